// File: rtl/wb_simple_master.sv
// -----------------------------------------------------------------------------
// wb_simple_master
//
// Single-outstanding Wishbone B4 (pipelined) initiator. Each command taken on
// the valid/ready request port becomes exactly one Wishbone read or write.
// The result comes back as one word on the valid/ready response port.
// Stall, err/rty/ack termination, a bounded number of re-issues after rty and
// an ack timeout are all handled here.
//
// Ports
//   clk_i, rst_n_i        clock; asynchronous active-low reset
//   req_valid_i/ready_o   command handshake (accepted when valid & ready)
//   req_we_i              1 = write, 0 = read
//   req_adr_i             byte address
//   req_dat_i, req_sel_i  write data and byte enables
//   rsp_valid_o/ready_i   response handshake (consumed when valid & ready)
//   rsp_dat_o             read data; 0 for writes and for errors
//   rsp_err_o             ended with err, retry exhaustion or timeout
//   rsp_timeout_o         the error was caused by the ack timeout
//   wb_*_o                Wishbone master outputs (cyc/stb registered)
//   wb_*_i                Wishbone slave responses
// -----------------------------------------------------------------------------
module wb_simple_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,   // multiple of 8
   parameter int unsigned TIMEOUT    = 255,  // 1..65535 WAIT cycles
   parameter int unsigned MAX_RETRY  = 3     // re-issues allowed after rty
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   // command port
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [ADDR_WIDTH-1:0]   req_adr_i,
   input  logic [DATA_WIDTH-1:0]   req_dat_i,
   input  logic [DATA_WIDTH/8-1:0] req_sel_i,
   // response port
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   // Wishbone master
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   input  logic                    wb_stall_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

   localparam int unsigned SEL_W   = DATA_WIDTH / 8;
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned TMO_W   = 16;

   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   // The counter starts at 0 in the first WAIT cycle, so the last permitted
   // WAIT cycle sees TIMEOUT-1.
   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT,
      ST_GAP,
      ST_RESP
   } state_t;

   state_t                state_q, state_d;

   logic                  cmd_we_q,  cmd_we_d;
   logic [ADDR_WIDTH-1:0] cmd_adr_q, cmd_adr_d;
   logic [DATA_WIDTH-1:0] cmd_dat_q, cmd_dat_d;
   logic [SEL_W-1:0]      cmd_sel_q, cmd_sel_d;

   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic [TMO_W-1:0]      tmo_q,   tmo_d;

   logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  rsp_tmo_q, rsp_tmo_d;

   logic                  cyc_q, cyc_d;
   logic                  stb_q, stb_d;

   // -------------------------------------------------------------------------
   // Next-state and datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d   = state_q;
      cmd_we_d  = cmd_we_q;
      cmd_adr_d = cmd_adr_q;
      cmd_dat_d = cmd_dat_q;
      cmd_sel_d = cmd_sel_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      rsp_tmo_d = rsp_tmo_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               cmd_we_d  = req_we_i;
               cmd_adr_d = req_adr_i;
               cmd_dat_d = req_dat_i;
               cmd_sel_d = req_sel_i;
               retry_d   = '0;
               tmo_d     = '0;
               state_d   = ST_STROBE;
            end
         end

         // Terminations count in the strobe acceptance cycle (STROBE with no
         // stall) and in every WAIT cycle; err beats rty beats ack.
         ST_STROBE, ST_WAIT: begin
            if ((state_q == ST_STROBE) && wb_stall_i) begin
               state_d = ST_STROBE;
            end else if (wb_err_i) begin
               rsp_err_d = 1'b1;
               state_d   = ST_RESP;
            end else if (wb_rty_i) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = ST_GAP;
               end else begin
                  rsp_err_d = 1'b1;
                  state_d   = ST_RESP;
               end
            end else if (wb_ack_i) begin
               rsp_dat_d = cmd_we_q ? '0 : wb_dat_i;
               state_d   = ST_RESP;
            end else if (state_q == ST_STROBE) begin
               state_d = ST_WAIT;
            end else if (tmo_q == TMO_LAST) begin
               rsp_err_d = 1'b1;
               rsp_tmo_d = 1'b1;
               state_d   = ST_RESP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         // One idle cycle with cyc low, then a full re-issue with a fresh
         // timeout window.
         ST_GAP: begin
            tmo_d   = '0;
            state_d = ST_STROBE;
         end

         // Response words are cleared on the handshake so the response port
         // reads all-zero while idle.
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_dat_d = '0;
               rsp_err_d = 1'b0;
               rsp_tmo_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // cyc/stb are flops fed from the next state, so no Wishbone input reaches
   // a Wishbone output within the same cycle and cyc falls on RESP entry.
   assign cyc_d = (state_d == ST_STROBE) || (state_d == ST_WAIT);
   assign stb_d = (state_d == ST_STROBE);

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: the datapath registers are reset along with the FSM so every
      // output is a known 0 out of reset, not just the control bits.
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cmd_we_q  <= 1'b0;
         cmd_adr_q <= '0;
         cmd_dat_q <= '0;
         cmd_sel_q <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
         rsp_tmo_q <= 1'b0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // values from before this edge, independent of statement order.
         state_q   <= state_d;
         cmd_we_q  <= cmd_we_d;
         cmd_adr_q <= cmd_adr_d;
         cmd_dat_q <= cmd_dat_d;
         cmd_sel_q <= cmd_sel_d;
         retry_q   <= retry_d;
         tmo_q     <= tmo_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
         rsp_tmo_q <= rsp_tmo_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign req_ready_o   = (state_q == ST_IDLE);
   assign rsp_valid_o   = (state_q == ST_RESP);
   assign rsp_dat_o     = rsp_dat_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_tmo_q;

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = cmd_we_q;
   assign wb_adr_o = cmd_adr_q;
   assign wb_sel_o = cmd_sel_q;
   assign wb_dat_o = cmd_dat_q;

endmodule

// File: tb/tb_wb_simple_master.sv
// -----------------------------------------------------------------------------
// tb_wb_simple_master
//
// Directed bench for wb_simple_master (TIMEOUT=8, MAX_RETRY=3). A scripted
// Wishbone slave inside tick() answers each strobe according to a few knobs:
// stall cycles, termination delay, number of rty answers and an err flag.
// tick() also counts strobe, WAIT and GAP cycles. All stimulus and sampling
// happen on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_wb_simple_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid_i, req_ready_o, req_we_i;
   logic [AW-1:0] req_adr_i;
   logic [DW-1:0] req_dat_i;
   logic [SW-1:0] req_sel_i;
   logic          rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
   logic [DW-1:0] rsp_dat_o;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0] wb_adr_o;
   logic [SW-1:0] wb_sel_o;
   logic [DW-1:0] wb_dat_o;
   logic          wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;
   logic [DW-1:0] wb_dat_i;

   always #5 clk = ~clk;

   wb_simple_master #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (8),
      .MAX_RETRY  (3)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_adr_i     (req_adr_i),
      .req_dat_i     (req_dat_i),
      .req_sel_i     (req_sel_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_dat_o     (rsp_dat_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_timeout_o (rsp_timeout_o),
      .wb_cyc_o      (wb_cyc_o),
      .wb_stb_o      (wb_stb_o),
      .wb_we_o       (wb_we_o),
      .wb_adr_o      (wb_adr_o),
      .wb_sel_o      (wb_sel_o),
      .wb_dat_o      (wb_dat_o),
      .wb_ack_i      (wb_ack_i),
      .wb_err_i      (wb_err_i),
      .wb_rty_i      (wb_rty_i),
      .wb_stall_i    (wb_stall_i),
      .wb_dat_i      (wb_dat_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   // slave knobs
   int            sl_stall;     // stall cycles at the start of every strobe
   int            sl_delay;     // cycles after acceptance to terminate; -1 never
   int            sl_rty_n;     // first sl_rty_n attempts answered with rty
   bit            sl_ack_too;   // raise ack together with rty
   bit            sl_err;       // final answer raises err+rty+ack together
   logic [DW-1:0] sl_dat;
   bit            force_ack;

   // slave / monitor state
   int stb_age, wait_age, attempt;
   int stb_cycles, wait_cycles, gap_cycles, strobes;
   bit bus_bad;
   logic          exp_we;
   logic [AW-1:0] exp_adr;
   logic [DW-1:0] exp_dat;
   logic [SW-1:0] exp_sel;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic respond();
      if (sl_delay >= 0 && wait_age == sl_delay) begin
         if (attempt < sl_rty_n) begin
            wb_rty_i = 1'b1;
            wb_ack_i = sl_ack_too;
         end else begin
            wb_ack_i = 1'b1;
            wb_err_i = sl_err;
            wb_rty_i = sl_err;
         end
         attempt++;
      end
   endtask

   // One clock: wait for the falling edge, observe, drive the slave.
   task automatic tick();
      @(negedge clk);
      wb_stall_i = 1'b0;
      wb_ack_i   = force_ack;
      wb_rty_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_dat_i   = sl_dat;
      if (wb_stb_o) begin
         stb_cycles++;
         if (wb_adr_o !== exp_adr || wb_dat_o !== exp_dat ||
             wb_sel_o !== exp_sel || wb_we_o !== exp_we || !wb_cyc_o)
            bus_bad = 1'b1;
         if (stb_age < sl_stall) begin
            wb_stall_i = 1'b1;
            stb_age++;
         end else begin
            strobes++;
            stb_age  = 0;
            wait_age = 0;
            respond();
         end
      end else if (wb_cyc_o) begin
         wait_cycles++;
         wait_age++;
         respond();
      end else if (!rsp_valid_o && !req_ready_o) begin
         gap_cycles++;
      end
   endtask

   task automatic new_test(input int stall, input int delay, input int rty_n,
                           input bit ack_too, input bit err, input logic [DW-1:0] dat);
      sl_stall = stall; sl_delay = delay; sl_rty_n = rty_n;
      sl_ack_too = ack_too; sl_err = err; sl_dat = dat;
      stb_age = 0; wait_age = 0; attempt = 0;
      stb_cycles = 0; wait_cycles = 0; gap_cycles = 0; strobes = 0;
      bus_bad = 1'b0;
   endtask

   // Returns with the command accepted and the first STROBE cycle observed.
   task automatic send_cmd(input string tag, input logic we, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat, input logic [SW-1:0] sel);
      exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
      tick();
      check({tag, " req_ready idle"}, req_ready_o, 1);
      req_valid_i = 1'b1; req_we_i = we; req_adr_i = adr;
      req_dat_i = dat; req_sel_i = sel;
      tick();
      req_valid_i = 1'b0;
   endtask

   // lat = cycles from the accept cycle until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid_o && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      check({tag, " rsp_valid after hs"}, rsp_valid_o, 0);
      check({tag, " req_ready after hs"}, req_ready_o, 1);
   endtask

   initial begin
      int  lat;
      bit  stable_bad, rsp_seen, cyc_seen;

      rst_n = 1'b0;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
      rsp_ready_i = 1'b0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
      force_ack = 1'b0;
      new_test(0, 0, 0, 1'b0, 1'b0, '0);

      // ---------------- reset values ----------------
      repeat (3) @(negedge clk);
      check("rst req_ready",   req_ready_o, 1);
      check("rst rsp_valid",   rsp_valid_o, 0);
      check("rst rsp_err",     {rsp_err_o, rsp_timeout_o}, 0);
      check("rst rsp_dat",     rsp_dat_o, 0);
      check("rst cyc/stb/we",  {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
      check("rst adr/sel/dat", {wb_adr_o, wb_sel_o, wb_dat_o[27:0]}, 0);
      rst_n = 1'b1;

      // ---------------- 1: read, no stall ----------------
      new_test(0, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      send_cmd("t1", 1'b0, 32'h4, 32'h0, 4'hF);
      check("t1 req_ready busy", req_ready_o, 0);
      wait_rsp(lat);
      check("t1 latency",    lat, 2);
      check("t1 stb cycles", stb_cycles, 1);
      check("t1 rsp_dat",    rsp_dat_o, 32'hDEAD_BEEF);
      check("t1 rsp_err",    {rsp_err_o, rsp_timeout_o}, 0);
      check("t1 cyc in resp", wb_cyc_o, 0);
      check("t1 bus fields", bus_bad, 0);
      finish_rsp("t1");

      // ---------------- 2: write with stall ----------------
      new_test(3, 2, 0, 1'b0, 1'b0, 32'hFFFF_0000);
      send_cmd("t2", 1'b1, 32'h0, 32'h1234_5678, 4'hF);
      wait_rsp(lat);
      check("t2 latency",    lat, 7);
      check("t2 stb cycles", stb_cycles, 4);
      check("t2 wait cycles", wait_cycles, 2);
      check("t2 rsp_dat",    rsp_dat_o, 0);
      check("t2 rsp_err",    rsp_err_o, 0);
      check("t2 bus stable", bus_bad, 0);
      finish_rsp("t2");

      // ---------------- 3: rty twice (ack raised too), then ack ----------------
      new_test(0, 0, 2, 1'b1, 1'b0, 32'hA5A5_0001);
      send_cmd("t3", 1'b0, 32'h8, 32'h0, 4'h3);
      wait_rsp(lat);
      check("t3 latency", lat, 6);
      check("t3 strobes", strobes, 3);
      check("t3 gaps",    gap_cycles, 2);
      check("t3 rsp_err", rsp_err_o, 0);
      check("t3 rsp_dat", rsp_dat_o, 32'hA5A5_0001);
      finish_rsp("t3");

      // ---------------- 4: retry exhaustion ----------------
      new_test(0, 0, 100, 1'b0, 1'b0, 32'hBAD0_BAD0);
      send_cmd("t4", 1'b0, 32'hC, 32'h0, 4'hF);
      wait_rsp(lat);
      check("t4 latency", lat, 8);
      check("t4 strobes", strobes, 4);
      check("t4 gaps",    gap_cycles, 3);
      check("t4 rsp_err/tmo", {rsp_err_o, rsp_timeout_o}, 2'b10);
      check("t4 rsp_dat", rsp_dat_o, 0);
      finish_rsp("t4");

      // ---------------- 4b: err+rty+ack together -> err wins ----------------
      new_test(0, 1, 0, 1'b0, 1'b1, 32'hBAD0_BAD0);
      send_cmd("t4b", 1'b0, 32'h14, 32'h0, 4'hF);
      wait_rsp(lat);
      check("t4b latency", lat, 3);
      check("t4b strobes", strobes, 1);
      check("t4b rsp_err/tmo", {rsp_err_o, rsp_timeout_o}, 2'b10);
      check("t4b rsp_dat", rsp_dat_o, 0);
      finish_rsp("t4b");

      // ---------------- 5: timeout, late ack ignored ----------------
      new_test(0, -1, 0, 1'b0, 1'b0, 32'h7777_7777);
      send_cmd("t5", 1'b0, 32'h18, 32'h0, 4'hF);
      wait_rsp(lat);
      check("t5 latency",    lat, 10);
      check("t5 wait cycles", wait_cycles, 8);
      check("t5 rsp_err/tmo", {rsp_err_o, rsp_timeout_o}, 2'b11);
      check("t5 cyc dropped", wb_cyc_o, 0);
      force_ack = 1'b1; wb_ack_i = 1'b1;
      tick();
      check("t5 late ack resp", {rsp_valid_o, rsp_err_o, rsp_timeout_o, wb_cyc_o}, 4'b1110);
      check("t5 late ack dat", rsp_dat_o, 0);
      force_ack = 1'b0;
      finish_rsp("t5");
      force_ack = 1'b1; wb_ack_i = 1'b1;
      tick();
      tick();
      check("t5 ack in idle", {rsp_valid_o, wb_cyc_o, req_ready_o}, 3'b001);
      force_ack = 1'b0;

      // ---------------- 6: backpressure, then reset mid-STROBE ----------------
      new_test(0, 0, 0, 1'b0, 1'b0, 32'h0BAD_F00D);
      send_cmd("t6", 1'b0, 32'h10, 32'h0, 4'hF);
      wait_rsp(lat);
      check("t6 latency", lat, 2);
      stable_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0BAD_F00D ||
             rsp_err_o !== 1'b0 || req_ready_o !== 1'b0)
            stable_bad = 1'b1;
      end
      check("t6 rsp held", stable_bad, 0);
      finish_rsp("t6");

      new_test(1000, 0, 0, 1'b0, 1'b0, 32'h0);
      send_cmd("t6r", 1'b1, 32'h20, 32'hCAFE_0001, 4'h1);
      tick();
      check("t6r in strobe", {wb_cyc_o, wb_stb_o}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check("t6r async drop", {wb_cyc_o, wb_stb_o}, 2'b00);
      check("t6r ready in rst", req_ready_o, 1);
      tick();
      tick();
      rst_n = 1'b1;
      rsp_seen = 1'b0; cyc_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         rsp_seen |= rsp_valid_o;
         cyc_seen |= wb_cyc_o;
      end
      check("t6r no response", rsp_seen, 0);
      check("t6r no cyc",      cyc_seen, 0);
      check("t6r ready after", req_ready_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_simple_master.md
Name: wb_simple_master

Overview:
- Single-outstanding Wishbone (pipelined, B4) initiator.
- Turns a valid/ready command port into one WB read or write per command and returns a response word.
- Sits on the initiator side of generated register banks and their submap ports; drives them from firmware-side or test logic.
- Handles stall, ack/err/rty termination, bounded retry and an ack timeout.

Parameters:
ADDR_WIDTH, 32, width of req_adr and wb_adr_o
DATA_WIDTH, 32, data width; must be a multiple of 8; SEL width is DATA_WIDTH/8
TIMEOUT, 255, max cycles with cyc high awaiting termination after strobe acceptance; range 1..65535
MAX_RETRY, 3, number of re-issues allowed after rty before reporting error; 0 means no re-issue

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  command valid
req_ready_o  out  1  command accepted when valid & ready
req_we_i  in  1  1=write, 0=read
req_adr_i  in  ADDR_WIDTH  byte address
req_dat_i  in  DATA_WIDTH  write data
req_sel_i  in  DATA_WIDTH/8  byte enables
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid & ready
rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err_o  out  1  transaction ended with err, retry exhaustion or timeout
rsp_timeout_o  out  1  error cause was timeout
wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  WB master controls
wb_adr_o  out  ADDR_WIDTH
wb_sel_o  out  DATA_WIDTH/8
wb_dat_o  out  DATA_WIDTH
wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each
wb_dat_i  in  DATA_WIDTH

Behaviour:
- Reset (async assert, sync release) values: all outputs 0 except req_ready_o=1. FSM=IDLE; counters 0. Reset mid-transaction drops cyc/stb immediately and discards the command without a response.
- FSM states: IDLE, STROBE, WAIT, GAP, RESP.
- IDLE:
  - req_ready_o=1.
  - On valid&ready, register we/adr/dat/sel and clear retry/timeout counters, then go to STROBE.
  - req_ready_o is 0 in every other state.
- STROBE:
  - cyc=stb=1, with address/data/sel/we from the registered command.
  - The strobe is accepted in the first cycle with wb_stall_i=0.
  - Once accepted, stb=0 in the next cycle and the FSM goes to WAIT. Otherwise stay in STROBE.
  - Termination inputs are sampled in the acceptance cycle and in WAIT. They are ignored while stall=1.
- WAIT:
  - cyc=1, stb=0.
  - The timeout counter increments each WAIT cycle.
- Termination priority when several inputs are high together: err > rty > ack.
- Termination outcomes:
  - ack: read latches wb_dat_i into rsp_dat_o (write gives 0), rsp_err=0, go to RESP.
  - err: rsp_err=1, go to RESP.
  - rty with retry_cnt < MAX_RETRY: increment retry_cnt, go to GAP.
  - rty with retry_cnt = MAX_RETRY: rsp_err=1, go to RESP.
- GAP: cyc=stb=0 for exactly one cycle, then STROBE (full re-issue). The timeout counter resets on re-issue.
- Timeout:
  - When the counter reaches TIMEOUT in WAIT with no termination, set rsp_err=1, rsp_timeout=1 and go to RESP.
  - Cyc drops the same cycle RESP is entered.
  - Stall cycles in STROBE are not counted.
- RESP:
  - cyc=0, rsp_valid=1, rsp_* held stable.
  - On rsp_ready_i=1, go to IDLE.
  - The next command is accepted no earlier than the cycle after the handshake.
- Latency: command accept to rsp_valid is 2 cycles minimum (accept → STROBE, ack same cycle → RESP visible next).
- wb_cyc_o and wb_stb_o are registered; no combinational path from wb_* inputs to wb_* outputs.
- Late ack/err/rty arriving in IDLE, GAP or RESP is ignored.

Test Plan:
1. Read, no stall: req adr=0x4, slave acks on the first strobe cycle with dat=0xDEADBEEF → stb high 1 cycle, rsp_valid 2 cycles after accept, rsp_dat=0xDEADBEEF, err=0.
2. Write with stall: adr=0x0, dat=0x12345678, sel=0xF; stall=1 for 3 cycles, ack 2 cycles after acceptance → stb high 4 cycles, wb_dat_o/sel stable throughout, rsp_dat=0, err=0.
3. Retry: slave returns rty twice, then ack (MAX_RETRY=3) → two GAP cycles with cyc=0, three strobes total, rsp_err=0.
4. Retry exhaustion: rty on every attempt with MAX_RETRY=3 → 4 strobes, then rsp_err=1, rsp_timeout=0.
5. Timeout: TIMEOUT=8, slave never terminates → cyc drops after 8 WAIT cycles, rsp_err=1, rsp_timeout=1; an ack arriving after that is ignored.
6. Backpressure and reset: hold rsp_ready=0 for 5 cycles → rsp stable, req_ready=0; then assert rst_n_i=0 mid-STROBE of a later command → cyc/stb go 0 asynchronously, req_ready=1 after release, no response emitted.
